// File: rtl/lattice_scan_gen_if.sv
// Cell stream from the lattice sweep sequencer to the collide/stream stage.
interface lattice_scan_gen_if #(
  parameter int unsigned GRID_W     = 16,
  parameter int unsigned GRID_H     = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(GRID_W * GRID_H),
  parameter int unsigned ROW_WIDTH  = $clog2(GRID_H),
  parameter int unsigned COL_WIDTH  = $clog2(GRID_W)
);
  logic                  Valid;
  logic                  Ready;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [ROW_WIDTH-1:0]  Row;
  logic [COL_WIDTH-1:0]  Col;
  logic [ADDR_WIDTH-1:0] Nbr_addr;
  logic                  Boundary;

  modport master (
    output Valid, Addr, Row, Col, Nbr_addr, Boundary,
    input  Ready
  );

  modport slave (
    input  Valid, Addr, Row, Col, Nbr_addr, Boundary,
    output Ready
  );
endinterface

// File: rtl/lattice_scan_gen.sv
// Lattice sweep sequencer: walks every cell in row-major order on Start and
// presents cell index, row, column, boundary flag and the periodic neighbour
// index in the latched D2Q9 direction under a valid/ready handshake.
module lattice_scan_gen #(
  parameter int unsigned GRID_W     = 16,
  parameter int unsigned GRID_H     = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(GRID_W * GRID_H),
  parameter int unsigned ROW_WIDTH  = $clog2(GRID_H),
  parameter int unsigned COL_WIDTH  = $clog2(GRID_W)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [3:0]         Dir,
  output logic               Busy,
  output logic               Done,
  lattice_scan_gen_if.master bus
);

  localparam logic [ROW_WIDTH-1:0] RowMax = ROW_WIDTH'(GRID_H - 1);
  localparam logic [COL_WIDTH-1:0] ColMax = COL_WIDTH'(GRID_W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e                state_q;
  logic [ROW_WIDTH-1:0]  row_q, row_nx;
  logic [COL_WIDTH-1:0]  col_q, col_nx;
  logic [3:0]            dir_q;
  logic                  valid_q, busy_q, done_q, bnd_q;
  logic [ADDR_WIDTH-1:0] addr_q, nbr_q;
  logic                  last_cell;

  function automatic logic [ADDR_WIDTH-1:0] lin_addr(input logic [ROW_WIDTH-1:0] r,
                                                     input logic [COL_WIDTH-1:0] c);
    return ADDR_WIDTH'(r) * ADDR_WIDTH'(GRID_W) + ADDR_WIDTH'(c);
  endfunction

  function automatic logic on_edge(input logic [ROW_WIDTH-1:0] r,
                                   input logic [COL_WIDTH-1:0] c);
    return (r == '0) || (r == RowMax) || (c == '0) || (c == ColMax);
  endfunction

  // Periodic neighbour; wrap done with compares so non-power-of-two grids work.
  function automatic logic [ADDR_WIDTH-1:0] nbr_addr(input logic [ROW_WIDTH-1:0] r,
                                                     input logic [COL_WIDTH-1:0] c,
                                                     input logic [3:0]           d);
    logic                 xp, xm, yp, ym;
    logic [ROW_WIDTH-1:0] nr;
    logic [COL_WIDTH-1:0] nc;
    xp = 1'b0;
    xm = 1'b0;
    yp = 1'b0;
    ym = 1'b0;
    case (d)
      4'd1:    xp = 1'b1;
      4'd2:    ym = 1'b1;
      4'd3:    xm = 1'b1;
      4'd4:    yp = 1'b1;
      4'd5:    begin xp = 1'b1; ym = 1'b1; end
      4'd6:    begin xm = 1'b1; ym = 1'b1; end
      4'd7:    begin xm = 1'b1; yp = 1'b1; end
      4'd8:    begin xp = 1'b1; yp = 1'b1; end
      default: ; // rest, including unused codes
    endcase
    nc = c;
    if (xp)      nc = (c == ColMax) ? '0 : c + COL_WIDTH'(1);
    else if (xm) nc = (c == '0) ? ColMax : c - COL_WIDTH'(1);
    nr = r;
    if (yp)      nr = (r == RowMax) ? '0 : r + ROW_WIDTH'(1);
    else if (ym) nr = (r == '0) ? RowMax : r - ROW_WIDTH'(1);
    return lin_addr(nr, nc);
  endfunction

  // Row-major successor of the current cell; wraps to (0,0) after the last one.
  always_comb begin
    row_nx = row_q;
    col_nx = col_q + COL_WIDTH'(1);
    if (col_q == ColMax) begin
      col_nx = '0;
      row_nx = (row_q == RowMax) ? '0 : row_q + ROW_WIDTH'(1);
    end
  end

  assign last_cell = (row_q == RowMax) && (col_q == ColMax);

  // Sweep FSM; every output is registered from the next cell coordinates.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      nbr_q   <= '0;
      bnd_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (Start) begin
            state_q <= StRun;
            row_q   <= '0;
            col_q   <= '0;
            dir_q   <= Dir;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            nbr_q   <= nbr_addr('0, '0, Dir);
            bnd_q   <= 1'b1;
          end
        end
        StRun: begin
          if (bus.Ready) begin
            row_q  <= row_nx;
            col_q  <= col_nx;
            addr_q <= lin_addr(row_nx, col_nx);
            nbr_q  <= nbr_addr(row_nx, col_nx, dir_q);
            bnd_q  <= on_edge(row_nx, col_nx);
            if (last_cell) begin
              state_q <= StFin;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Valid    = valid_q;
  assign bus.Addr     = addr_q;
  assign bus.Row      = row_q;
  assign bus.Col      = col_q;
  assign bus.Nbr_addr = nbr_q;
  assign bus.Boundary = bnd_q;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_lattice_scan_gen.sv
// Scoreboard bench for lattice_scan_gen: expected cells are queued at Start,
// a negedge monitor pops and compares on every Valid&Ready transfer.
module tb_lattice_scan_gen;

  localparam int W = 16;
  localparam int H = 16;

  typedef struct {
    int addr;
    int row;
    int col;
    int nbr;
    int bnd;
  } cell_t;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [3:0] Dir;
  logic       Busy;
  logic       Done;

  lattice_scan_gen_if #(.GRID_W(W), .GRID_H(H)) bus ();

  lattice_scan_gen #(.GRID_W(W), .GRID_H(H)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Dir   (Dir),
    .Busy  (Busy),
    .Done  (Done),
    .bus   (bus)
  );

  int    n_tests  = 0;
  int    n_fail   = 0;
  int    xfer_cnt = 0;
  int    done_cnt = 0;
  int    cur_dir  = 0;
  cell_t exp_q[$];

  // Independent spot values: {dir, addr, expected neighbour}.
  int spots[9][3] = '{
    '{1, 15, 0}, '{1, 20, 21}, '{1, 255, 240}, '{5, 15, 240}, '{7, 240, 15},
    '{8, 255, 0}, '{12, 37, 37}, '{0, 200, 200}, '{3, 16, 31}
  };

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference: row-major cell with periodic neighbour via plain modulo arithmetic.
  function automatic cell_t model(input int a, input int d);
    cell_t c;
    int    dx, dy;
    dx = 0;
    dy = 0;
    case (d)
      1: dx = 1;
      2: dy = -1;
      3: dx = -1;
      4: dy = 1;
      5: begin dx = 1;  dy = -1; end
      6: begin dx = -1; dy = -1; end
      7: begin dx = -1; dy = 1;  end
      8: begin dx = 1;  dy = 1;  end
      default: ;
    endcase
    c.addr = a;
    c.row  = a / W;
    c.col  = a % W;
    c.nbr  = ((c.row + dy + H) % H) * W + (c.col + dx + W) % W;
    c.bnd  = (c.row == 0 || c.row == H - 1 || c.col == 0 || c.col == W - 1) ? 1 : 0;
    return c;
  endfunction

  // Monitor: scoreboard pops, stall stability and Done counting.
  initial begin
    logic [25:0] cur, held;
    bit          stall_prev;
    cell_t       e;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        stall_prev = 1'b0;
      end else begin
        cur = {bus.Valid, bus.Addr, bus.Row, bus.Col, bus.Nbr_addr, bus.Boundary};
        if (stall_prev) chk("hold_while_stalled", int'(cur), int'(held));
        if (Done) done_cnt++;
        if (bus.Valid && bus.Ready) begin
          xfer_cnt++;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_transfer: got addr=%0d, expected no transfer",
                     bus.Addr);
          end else begin
            e = exp_q.pop_front();
            if (int'(bus.Addr) != e.addr || int'(bus.Row) != e.row ||
                int'(bus.Col) != e.col || int'(bus.Nbr_addr) != e.nbr ||
                int'(bus.Boundary) != e.bnd) begin
              n_fail++;
              $display("FAIL cell: got addr=%0d row=%0d col=%0d nbr=%0d bnd=%0d, expected addr=%0d row=%0d col=%0d nbr=%0d bnd=%0d",
                       bus.Addr, bus.Row, bus.Col, bus.Nbr_addr, bus.Boundary,
                       e.addr, e.row, e.col, e.nbr, e.bnd);
            end
          end
          for (int i = 0; i < 9; i++)
            if (spots[i][0] == cur_dir && spots[i][1] == int'(bus.Addr))
              chk("spot_nbr", int'(bus.Nbr_addr), spots[i][2]);
          if (bus.Addr == 17) chk("boundary_interior_17", int'(bus.Boundary), 0);
          if (bus.Addr == 31) chk("boundary_col15_31", int'(bus.Boundary), 1);
        end
        stall_prev = bus.Valid && !bus.Ready;
        held       = cur;
      end
    end
  end

  task automatic start_sweep(input int d, input bit rnd);
    xfer_cnt = 0;
    cur_dir  = d;
    for (int a = 0; a < W * H; a++) exp_q.push_back(model(a, d));
    @(posedge Clk); #1;
    Start     = 1'b1;
    Dir       = 4'(d);
    bus.Ready = rnd ? 1'($urandom % 2) : 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("valid_latency", int'(bus.Valid), 1);
    chk("busy_in_run", int'(Busy), 1);
    chk("first_addr", int'(bus.Addr), 0);
  endtask

  task automatic run_sweep(input int d, input bit rnd, input bit noise);
    int dc0;
    int k;
    bit seen;
    dc0 = done_cnt;
    start_sweep(d, rnd);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 3000) begin
      if (noise) begin
        Start = 1'($urandom % 2);
        Dir   = 4'($urandom);
      end
      if (rnd) bus.Ready = 1'($urandom % 2);
      @(posedge Clk); #1;
      k++;
      if (Done) seen = 1'b1;
    end
    Start = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no Done after %0d cycles, expected one", k);
    end
    if (!rnd) chk("done_cycle", k + 1, 257);
    chk("busy_in_fin", int'(Busy), 0);
    chk("valid_in_fin", int'(bus.Valid), 0);
    @(posedge Clk); #1;
    chk("done_one_cycle", int'(Done), 0);
    chk("busy_after", int'(Busy), 0);
    chk("transfers", xfer_cnt, W * H);
    chk("queue_drained", exp_q.size(), 0);
    chk("done_count", done_cnt - dc0, 1);
  endtask

  initial begin
    int  dc0;
    bit  hit;
    Reset     = 1'b0;
    Start     = 1'b0;
    Dir       = 4'd0;
    bus.Ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_valid", int'(bus.Valid), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_boundary", int'(bus.Boundary), 0);
    chk("rst_addr", int'(bus.Addr), 0);
    chk("rst_nbr", int'(bus.Nbr_addr), 0);
    Reset = 1'b1;

    run_sweep(0, 1'b0, 1'b0);
    run_sweep(1, 1'b0, 1'b0);
    run_sweep(5, 1'b1, 1'b1);
    run_sweep(7, 1'b1, 1'b1);
    run_sweep(8, 1'b1, 1'b0);
    run_sweep(12, 1'b0, 1'b0);

    // Abort mid-sweep with reset at Addr 100.
    start_sweep(3, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      if (bus.Valid && bus.Addr == 100) hit = 1'b1;
      else begin
        @(posedge Clk); #1;
      end
    end
    chk("abort_reached_100", int'(hit), 1);
    dc0   = done_cnt;
    Reset = 1'b0;
    #1;
    chk("abort_valid", int'(bus.Valid), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_addr", int'(bus.Addr), 0);
    chk("abort_row", int'(bus.Row), 0);
    chk("abort_col", int'(bus.Col), 0);
    chk("abort_nbr", int'(bus.Nbr_addr), 0);
    chk("abort_boundary", int'(bus.Boundary), 0);
    exp_q.delete();
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_idle_valid", int'(bus.Valid), 0);

    run_sweep(2, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lattice_scan_gen.md
Name: lattice_scan_gen

Overview:
- Sweep sequencer for the LBM lattice.
- On Start, it walks every cell in row-major order and emits the linear cell index with its row and column.
- It also emits the periodic-wrapped neighbour index for one selected D2Q9 streaming direction.
- It drives the per-cell linear index consumed by the row-tracking and streaming logic.
- It stalls under a valid/ready handshake with the downstream collide/stream stage.

Parameters:
- GRID_W, 16, lattice width in cells (columns).
- GRID_H, 16, lattice height in cells (rows).
- ADDR_WIDTH, $clog2(GRID_W*GRID_H), width of linear cell index.
- ROW_WIDTH, $clog2(GRID_H), width of row index.
- COL_WIDTH, $clog2(GRID_W), width of column index.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  begin sweep; sampled only in IDLE.
- Dir  input  4  D2Q9 direction, latched on accepted Start.
- Ready  input  1  downstream accepts the current cell.
- Valid  output  1  current cell outputs are valid.
- Addr  output  ADDR_WIDTH  linear index, row*GRID_W+col.
- Row  output  ROW_WIDTH  current row.
- Col  output  COL_WIDTH  current column.
- Nbr_addr  output  ADDR_WIDTH  linear index of the neighbour in the latched Dir.
- Boundary  output  1  cell lies on the outer lattice edge.
- Busy  output  1  sweep in progress (state RUN).
- Done  output  1  one-cycle pulse after the last cell is accepted.

Behaviour:
- Reset (async, Reset=0): state IDLE. Valid, Busy, Done, Boundary = 0. Addr, Row, Col, Nbr_addr = 0. Latched Dir = 0.
- Reset mid-sweep aborts immediately. No Done is issued.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - Start=1 latches Dir and loads row=0, col=0. Next state RUN.
  - Valid=1 from the following cycle, so latency Start->first Valid is 1 cycle.
- RUN:
  - Valid=1 and Busy=1.
  - A transfer occurs on any cycle with Valid&Ready.
  - If Ready=0, all outputs hold stable.
  - On transfer: col+1. If col==GRID_W-1, col->0 and row+1.
  - On transfer of the cell (GRID_H-1, GRID_W-1): next state FIN, Valid->0.
- FIN: Done=1 for exactly one cycle, Valid=0, Busy=0. Next state IDLE.
- Start while in RUN or FIN is ignored. A Dir change mid-sweep is ignored.
- Back-to-back: Start in the cycle after FIN (i.e. in IDLE) is accepted normally.
- All outputs are registered and are a function of the registered row, col and Dir. There is no combinational path from Start or Ready to any output.
- Addr = row*GRID_W+col, computed at ADDR_WIDTH. When GRID_W is a power of two this reduces to {row,col}.
- Boundary = (row==0)|(row==GRID_H-1)|(col==0)|(col==GRID_W-1).
- Direction offsets (dx, dy); +dy means row+1:
  - 0 rest (0,0)
  - 1 E (+1,0)
  - 2 N (0,-1)
  - 3 W (-1,0)
  - 4 S (0,+1)
  - 5 NE (+1,-1)
  - 6 NW (-1,-1)
  - 7 SW (-1,+1)
  - 8 SE (+1,+1)
  - Codes 9-15 are treated as 0 (rest).
- Neighbour computation: periodic wrap on both axes, using explicit compares rather than modulo.
  - ncol = col+dx wrapped into 0..GRID_W-1.
  - nrow = row+dy wrapped into 0..GRID_H-1.
  - Nbr_addr = nrow*GRID_W+ncol.
- Total transfers per sweep = GRID_W*GRID_H exactly. There are no duplicate or skipped indices, regardless of the Ready pattern.

Test Plan:
- Reset, then Start=1, Dir=0, Ready=1 constant -> Valid high from cycle 1 for 256 cycles, Addr 0..255 in order, Row=Addr>>4, Col=Addr&15, Nbr_addr=Addr. Done pulses once at cycle 257, Busy low after.
- Dir=1 (E), Ready=1 -> at Addr=15 (row0,col15) Nbr_addr=0; at Addr=20 Nbr_addr=21; at Addr=255 Nbr_addr=240.
- Dir=5 (NE) -> Addr=15 gives Nbr_addr=240. Dir=7 (SW) -> Addr=240 gives Nbr_addr=15. Dir=8 (SE) -> Addr=255 gives Nbr_addr=0.
- Ready toggling randomly (~50%) -> outputs stable while Ready=0, exactly 256 transfers with unique Addr 0..255, Done exactly once. Start pulses during RUN are ignored and Dir changes mid-sweep have no effect.
- Reset asserted at Addr=100 -> all outputs 0 immediately, no Done. A new Start afterwards restarts at Addr=0.
- Boundary check -> Boundary=1 for Addr 0..15, 240..255, and Col 0/15; Boundary=0 for Addr=17. Dir=12 behaves as rest (Nbr_addr=Addr).
